// File: rtl/mbist_pkg.sv
// mbist_pkg: FSM states and the March C- element table shared by the MBIST controller
package mbist_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;
  typedef struct packed {
    logic up;
    logic rv;
    logic wv;
    logic has_rd;
    logic has_wr;
  } elem_t;
  localparam int NUM_ELEM = 6;
  localparam elem_t [0:7] MARCH = '{
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
    '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
    '0,
    '0
  };
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down march address counter with direction-aware load and last-address flag
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              ld_up,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  // load the element's start address or walk one step in its direction
  always_ff @(posedge clk) begin
    if (rst) addr <= '0;
    else if (ld) addr <= ld_up ? '0 : '1;
    else if (step) addr <= up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
  end
  assign last = up ? &addr : ~|addr;
endmodule

// File: rtl/mbist_ctrl.sv
// mbist_ctrl: March C- SRAM BIST controller with duration limit; MBIST_FAULT_INJ_EN adds compare-side fault injection
module mbist_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DUR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DUR_W-1:0]  dur_limit,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MBIST_FAULT_INJ_EN
  ,
  input  logic              fi_en,
  input  logic [ADDR_W-1:0] fi_addr,
  input  logic [DATA_W-1:0] fi_mask
`endif
);
  state_t state, state_nx;
  logic [2:0] elem, elem_nx;
  logic [DUR_W-1:0] cyc_cnt, lim;
  logic [DATA_W-1:0] cmp_data;
  logic last, ld, step, accept, fin, tmo, bad, adv;
`ifdef MBIST_FAULT_INJ_EN
  assign cmp_data = mem_rdata ^ ((fi_en && mem_addr == fi_addr) ? fi_mask : '0);
`else
  assign cmp_data = mem_rdata;
`endif
  assign elem_nx = elem + 3'd1;
  assign busy = state == WR || state == RD || state == CMP;
  assign accept = start && (state == IDLE || state == DONE);
  assign fin = state == CMP && elem == 3'(NUM_ELEM - 1) && last;
  assign adv = last && (state == WR || state == CMP);
  assign tmo = busy && lim != '0 && cyc_cnt == lim - DUR_W'(1) && !fin;
  assign bad = state == CMP && cmp_data != {DATA_W{MARCH[elem].rv}};
  assign mem_we = state == WR || (state == CMP && MARCH[elem].has_wr);
  assign mem_en = mem_we || state == RD;
  assign mem_wdata = mem_we ? {DATA_W{MARCH[elem].wv}} : '0;
  assign ld = accept || (adv && !fin);
  assign step = (state == WR || state == CMP) && !last;
  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .ld_up (accept || MARCH[elem_nx].up),
    .step  (step),
    .up    (MARCH[elem].up),
    .addr  (mem_addr),
    .last  (last)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // march sequencing: abort on mismatch or duration limit, otherwise walk elements
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? WR : state;
      WR:         state_nx = tmo ? DONE : (last && MARCH[elem_nx].has_rd) ? RD : WR;
      RD:         state_nx = tmo ? DONE : CMP;
      CMP:        state_nx = (bad || tmo || fin) ? DONE : (last && !MARCH[elem_nx].has_rd) ? WR : RD;
      default:    state_nx = IDLE;
    endcase
  end
  // run bookkeeping: element index, busy-cycle count, sampled limit and status flags
  always_ff @(posedge clk) begin
    if (rst) {elem, cyc_cnt, lim, done, pass, timeout, fail_addr, fail_elem} <= '0;
    else if (accept) begin
      elem <= '0;
      cyc_cnt <= '0;
      lim <= dur_limit;
      {done, pass, timeout, fail_addr, fail_elem} <= '0;
    end else if (busy) begin
      cyc_cnt <= cyc_cnt + DUR_W'(1);
      if (adv && !fin) elem <= elem_nx;
      if (state_nx == DONE) begin
        done <= 1'b1;
        pass <= !bad && !tmo;
        timeout <= tmo;
      end
      if (bad) begin
        fail_addr <= mem_addr;
        fail_elem <= elem;
      end
    end
  end
endmodule

// File: tb/tb_mbist_ctrl.sv
// tb_mbist_ctrl: randomized scoreboard bench for mbist_ctrl against an op-level March C- model
module tb_mbist_ctrl;
  localparam int N = 16;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] dur_limit = '0;
  logic busy, done, pass, timeout, mem_en, mem_we;
  logic [3:0] fail_addr, mem_addr;
  logic [2:0] fail_elem;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
`ifdef MBIST_FAULT_INJ_EN
  logic fi_en = 0;
  logic [3:0] fi_addr = '0;
  logic [7:0] fi_mask = '0;
`endif
  mbist_ctrl #(.ADDR_W(4), .DATA_W(8), .DUR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dur_limit(dur_limit),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MBIST_FAULT_INJ_EN
    , .fi_en(fi_en), .fi_addr(fi_addr), .fi_mask(fi_mask)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] sram [N];
  int sa = -1, sb = 0;
  logic sv = 0;
  function automatic logic [7:0] rd_fault(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (a == sa) r[sb] = sv;
    return r;
  endfunction
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= rd_fault(int'(mem_addr), sram[mem_addr]);
    end
  int e_up [6] = '{1, 1, 1, 0, 0, 1};
  int e_rv [6] = '{0, 0, 1, 0, 1, 0};
  int e_wv [6] = '{0, 1, 0, 1, 0, 0};
  int e_hr [6] = '{0, 1, 1, 1, 1, 1};
  int e_hw [6] = '{1, 1, 1, 1, 1, 0};
  typedef struct {int k; int busy; int pass; int tmo; int fa; int fe;} exp_t;
  exp_t q [$];
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask
  function automatic exp_t model(input int lim, input int k);
    logic [7:0] m [N];
    logic [7:0] d;
    exp_t x;
    int c, a, t;
    c = 0;
    x = '{k, 0, 1, 0, 0, 0};
    for (int e = 0; e < 6; e++)
      for (int s = 0; s < N; s++) begin
        a = e_up[e] ? s : N - 1 - s;
        if (lim != 0 && c == lim - 1) begin
          x.busy = c + 1; x.pass = 0; x.tmo = 1;
          return x;
        end
        if (e_hr[e] != 0) begin
          c++;
          d = rd_fault(a, m[a]);
`ifdef MBIST_FAULT_INJ_EN
          if (fi_en && a == int'(fi_addr)) d = d ^ fi_mask;
`endif
          t = (lim != 0 && c == lim - 1 && !(e == 5 && s == N - 1)) ? 1 : 0;
          if (d != {8{e_rv[e][0]}} || t != 0) begin
            x.busy = c + 1; x.pass = 0; x.tmo = t;
            if (d != {8{e_rv[e][0]}}) begin x.fa = a; x.fe = e; end
            return x;
          end
        end
        if (e_hw[e] != 0) m[a] = {8{e_wv[e][0]}};
        c++;
      end
    x.busy = c;
    return x;
  endfunction
  exp_t mx;
  logic done_q = 0, busy_q = 0;
  int bcnt = 0;
  // monitor: score every completed run against the queued expectation
  always @(negedge clk) begin
    if (busy && !busy_q) bcnt = 0;
    if (busy) bcnt++;
    if (!busy) chk("mem_en_idle", int'(mem_en), 0);
    if (done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mx = q.pop_front();
        chk("latency", cyc - mx.k, mx.busy);
        chk("busy_cycles", bcnt, mx.busy);
        chk("pass", int'(pass), mx.pass);
        chk("timeout", int'(timeout), mx.tmo);
        chk("fail_addr", int'(fail_addr), mx.fa);
        chk("fail_elem", int'(fail_elem), mx.fe);
      end
    end
    done_q = done;
    busy_q = busy;
  end
  task automatic run(input int lim, input int mid, input int abort_at);
    exp_t x;
    int k;
    @(negedge clk);
    dur_limit = 16'(lim);
    start = 1;
    k = cyc + 1;
    x = model(lim, k);
    q.push_back(x);
    @(negedge clk);
    start = 0;
    dur_limit = 16'($urandom);
    chk("accept_flags", int'({busy, done, pass, timeout, fail_addr, fail_elem}), 1 << 10);
    for (int i = 0; i < 400 && !done; i++) begin
      start = (mid != 0 && cyc == k + mid - 1);
      if (abort_at != 0 && cyc == k + abort_at - 1) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_outputs", int'({busy, done, pass, timeout, fail_addr, fail_elem,
                                   mem_en, mem_we, mem_addr, mem_wdata}), 0);
        void'(q.pop_back());
        return;
      end
      @(negedge clk);
    end
    start = 0;
    if (!done) chk("done_within_budget", 0, 1);
  endtask
  initial begin
    int lim;
    @(negedge clk);
    chk("reset_outputs", int'({busy, done, pass, timeout, fail_addr, fail_elem,
                               mem_en, mem_we, mem_addr, mem_wdata}), 0);
    rst = 0;
    run(0, 0, 0);
    sa = 5; sb = 0; sv = 1;
    run(0, 0, 0);
    sa = -1;
    run(50, 0, 0);
    run(0, 20, 0);
    run(0, 0, 0);
    run(0, 0, 90);
    run(0, 0, 0);
    run(176, 0, 0);
    run(175, 0, 0);
    run(1, 0, 0);
    run(2, 0, 0);
`ifdef MBIST_FAULT_INJ_EN
    fi_en = 1; fi_addr = 4'd3; fi_mask = 8'h01;
    run(0, 0, 0);
    fi_en = 0;
    run(0, 0, 0);
`endif
    repeat (16) begin
      sa = ($urandom % 2 != 0) ? int'($urandom_range(0, N - 1)) : -1;
      sb = int'($urandom_range(0, 7));
      sv = 1'($urandom % 2);
      lim = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 200));
      run(lim, 0, 0);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
